// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: operand width, loop counter
// preload and the controller state encoding.
package mult_pkg;

  localparam int N_BITS = 8;
  localparam int COUNT_W = 4;

  // The counter runs N_BITS-1 .. 0, giving exactly N_BITS SHIFT cycles.
  localparam logic [COUNT_W-1:0] COUNT_PRELOAD = COUNT_W'(N_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_TEST,
    ST_ADD,
    ST_SHIFT,
    ST_DONE
  } mult_state_t;

endpackage

// File: rtl/mult_controller.sv
// Control FSM for the shift-add multiplier: sequences LOAD/ADD/SHIFT strobes,
// drives the loop counter and handshakes start/result with the host.
module mult_controller
  import mult_pkg::*;
(
  input  logic       clk,
  input  logic       n_reset,
  input  logic       start,
  input  logic       q0,
  input  logic [3:0] count,
  input  logic       result_ack,
  output logic       LOAD,
  output logic       RESET,
  output logic       ADD,
  output logic       SHIFT,
  output logic       DECREMENT,
  output logic       ready,
  output logic       done
);

  mult_state_t state;
  mult_state_t state_next;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    LOAD       = 1'b0;
    RESET      = 1'b0;
    ADD        = 1'b0;
    SHIFT      = 1'b0;
    DECREMENT  = 1'b0;
    ready      = 1'b0;
    done       = 1'b0;

    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          state_next = ST_LOAD;
        end
      end

      ST_LOAD: begin
        LOAD       = 1'b1;
        RESET      = 1'b1;
        state_next = ST_TEST;
      end

      ST_TEST: begin
        state_next = q0 ? ST_ADD : ST_SHIFT;
      end

      ST_ADD: begin
        ADD        = 1'b1;
        state_next = ST_SHIFT;
      end

      // The last shift happens at count==0; decrementing there would wrap
      // the counter to 15, so the decrement is withheld on that final pass.
      ST_SHIFT: begin
        SHIFT = 1'b1;
        if (count == 4'd0) begin
          state_next = ST_DONE;
        end else begin
          DECREMENT  = 1'b1;
          state_next = ST_TEST;
        end
      end

      ST_DONE: begin
        done = 1'b1;
        if (result_ack) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mult_controller.sv
// Randomized bench for mult_controller: a datapath/counter model closes the
// loop, and results are judged against arithmetic products and cycle formulas.
module tb_mult_controller;
  import mult_pkg::*;

  logic       clk = 1'b0;
  logic       n_reset = 1'b0;
  logic       start = 1'b0;
  logic       result_ack = 1'b0;
  logic       q0;
  logic [3:0] count;
  logic       LOAD, RESET, ADD, SHIFT, DECREMENT, ready, done;

  int n_chk = 0;
  int n_pass = 0;

  mult_controller dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .start      (start),
    .q0         (q0),
    .count      (count),
    .result_ack (result_ack),
    .LOAD       (LOAD),
    .RESET      (RESET),
    .ADD        (ADD),
    .SHIFT      (SHIFT),
    .DECREMENT  (DECREMENT),
    .ready      (ready),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Environment: datapath registers and loop counter reacting to the strobes.
  logic [7:0] m_a = '0, m_q = '0, m_m = '0;
  logic       m_c = 1'b0;
  logic [3:0] cnt = '0;
  logic [7:0] mcand_in = '0, mplier_in = '0;
  logic       s_load = 1'b0, s_reset = 1'b0, s_add = 1'b0, s_shift = 1'b0, s_dec = 1'b0;

  assign q0    = m_q[0];
  assign count = cnt;

  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      cnt <= '0;
    end else begin
      if (s_reset && !s_dec) cnt <= COUNT_PRELOAD;
      else if (s_dec && !s_reset) cnt <= cnt - 4'd1;
      if (s_load) begin
        m_a <= '0;
        m_c <= 1'b0;
        m_q <= mplier_in;
        m_m <= mcand_in;
      end else if (s_add) begin
        {m_c, m_a} <= {1'b0, m_a} + {1'b0, m_m};
      end else if (s_shift) begin
        {m_c, m_a, m_q} <= {1'b0, m_c, m_a, m_q[7:1]};
      end
    end
  end

  // Strobe tallies and invariant watch, sampled mid-cycle.
  int tot_load = 0, tot_reset = 0, tot_add = 0, tot_shift = 0, tot_dec = 0;
  int add_log[1024];
  int v_rst_dec = 0, v_dec_zero = 0, v_rdy_done = 0;

  always @(negedge clk) begin
    s_load  = LOAD;
    s_reset = RESET;
    s_add   = ADD;
    s_shift = SHIFT;
    s_dec   = DECREMENT;
    if (LOAD) tot_load++;
    if (RESET) tot_reset++;
    if (ADD) begin
      add_log[tot_add % 1024] = tot_shift;
      tot_add++;
    end
    if (SHIFT) tot_shift++;
    if (DECREMENT) tot_dec++;
    if (RESET && DECREMENT) v_rst_dec++;
    if (DECREMENT && count == 4'd0) v_dec_zero++;
    if (ready && done) v_rdy_done++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int strobes();
    return int'({LOAD, RESET, ADD, SHIFT, DECREMENT});
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ready"}, int'(ready), 1);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_strobes"}, strobes(), 0);
  endtask

  task automatic run_op(input logic [7:0] mc, input logic [7:0] mp, input int hold,
                        input bit ack_with_start, input bit noise);
    int lat, mask;
    int b_load, b_reset, b_add, b_shift, b_dec;
    mcand_in  = mc;
    mplier_in = mp;
    chk("op_ready", int'(ready), 1);
    b_load = tot_load; b_reset = tot_reset; b_add = tot_add; b_shift = tot_shift; b_dec = tot_dec;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("op_load_reset", int'({LOAD, RESET, ready}), 3'b110);
    lat = 1;
    while (!done && lat < 100) begin
      if (noise) begin
        start      = 1'($urandom_range(0, 1));
        result_ack = 1'($urandom_range(0, 1));
      end
      tick();
      lat++;
    end
    start      = 1'b0;
    result_ack = 1'b0;
    chk("op_latency", lat, 2 + 2 * N_BITS + $countones(mp));
    chk("op_loads", tot_load - b_load, 1);
    chk("op_resets", tot_reset - b_reset, 1);
    chk("op_adds", tot_add - b_add, $countones(mp));
    chk("op_shifts", tot_shift - b_shift, N_BITS);
    chk("op_decs", tot_dec - b_dec, N_BITS - 1);
    mask = 0;
    for (int i = b_add; i < tot_add; i++) mask |= (1 << (add_log[i % 1024] - b_shift));
    chk("op_add_bits", mask, int'(mp));
    chk("op_product", int'({m_a, m_q}), int'(mc) * int'(mp));
    chk("op_count_end", int'(count), 0);

    b_load = tot_load; b_reset = tot_reset; b_add = tot_add; b_shift = tot_shift; b_dec = tot_dec;
    for (int i = 0; i < hold; i++) begin
      start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      tick();
      chk("hold_done", int'({done, ready}), 2'b10);
    end
    start = 1'b0;
    chk("hold_strobes", (tot_load - b_load) + (tot_reset - b_reset) + (tot_add - b_add)
        + (tot_shift - b_shift) + (tot_dec - b_dec), 0);

    result_ack = 1'b1;
    start      = ack_with_start;
    tick();
    result_ack = 1'b0;
    start      = 1'b0;
    chk_idle("ack");
    tick();
    chk_idle("post_ack");
  endtask

  // target: 0 = LOAD, 1 = ADD, 2 = SHIFT, 3 = DONE
  task automatic reset_in(input int target);
    int n;
    mcand_in  = 8'($urandom);
    mplier_in = 8'($urandom) | 8'h03;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    case (target)
      1: while (!ADD && n < 60) begin tick(); n++; end
      2: begin
        while (!SHIFT && n < 60) begin tick(); n++; end
        tick();
        while (!SHIFT && n < 60) begin tick(); n++; end
      end
      3: while (!done && n < 60) begin tick(); n++; end
      default: ;
    endcase
    chk("rst_reached", int'(n < 60), 1);
    n_reset = 1'b0;
    tick();
    chk_idle("rst_abort");
    n_reset = 1'b1;
    tick();
    chk_idle("rst_after");
  endtask

  initial begin
    repeat (3) tick();
    chk_idle("reset_low");
    n_reset = 1'b1;
    tick();
    chk_idle("reset_release");

    run_op(8'h5A, 8'h00, 1, 1'b0, 1'b0);
    run_op(8'h03, 8'hA5, 5, 1'b0, 1'b1);
    run_op(8'hFF, 8'hFF, 0, 1'b1, 1'b0);
    for (int t = 0; t < 4; t++) reset_in(t);
    repeat (20) begin
      run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 4)),
             1'($urandom_range(0, 1)), 1'b1);
    end

    chk("inv_reset_and_dec", v_rst_dec, 0);
    chk("inv_dec_at_zero", v_dec_zero, 0);
    chk("inv_ready_and_done", v_rdy_done, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
